// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the cpu3 pipeline sequencer.
// Holds FSM states, scoreboard entry layout and the ID/EX NOP bundle.
package cpu_ctrl_pkg;

    localparam int REG_BITS = 5;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] waddr;
    } sb_entry_t;

    typedef struct packed {
        logic rw_;
        logic mem_rw_;
        logic halt;
    } ctrl_t;

    // pipe_id_ex loads this when idex_bubble is set
    localparam ctrl_t CTRL_NOP = '{rw_: 1'b1, mem_rw_: 1'b1, halt: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Shadow scoreboard of in-flight register writers (EX, MEM, WB).
// Flags RAW hazards for the decode stage sources.
module hazard_scoreboard
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_BITS = REG_BITS,
    parameter int DEPTH         = 3
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     push,
    input  logic [REG_ADDR_BITS-1:0] push_addr,
    input  logic                     chk_valid,
    input  logic                     use_r1,
    input  logic                     use_r2,
    input  logic [REG_ADDR_BITS-1:0] r1_addr,
    input  logic [REG_ADDR_BITS-1:0] r2_addr,
    output logic                     hazard,
    output logic                     pipe_empty
);

    logic [DEPTH-1:0]         valid;
    logic [REG_ADDR_BITS-1:0] waddr [DEPTH];
    logic                     hit1;
    logic                     hit2;

    // r0 is hardwired, so writes to it never block a reader
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr[i] <= '0;
            end
        end else begin
            valid[0] <= push & (|push_addr);
            waddr[0] <= push_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                waddr[i] <= waddr[i-1];
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (valid[i] & (waddr[i] == r1_addr));
            hit2 = hit2 | (valid[i] & (waddr[i] == r2_addr));
        end
    end

    assign hazard = chk_valid
                  & ((use_r1 & (|r1_addr) & hit1)
                  |  (use_r2 & (|r2_addr) & hit2));

    assign pipe_empty = ~|valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage cpu3 pipeline: stalls, squash,
// halt/exception drain and a saturating stall counter.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_BITS = REG_BITS,
    parameter int DEPTH         = 3,
    parameter int CNT_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [REG_ADDR_BITS-1:0] id_r1_addr,
    input  logic [REG_ADDR_BITS-1:0] id_r2_addr,
    input  logic                     id_use_r1,
    input  logic                     id_use_r2,
    input  logic                     id_rw_,
    input  logic [REG_ADDR_BITS-1:0] id_waddr,
    input  logic                     id_jmp,
    input  logic                     id_jreg,
    input  logic                     id_breq,
    input  logic                     id_brne,
    input  logic                     id_equal,
    input  logic                     id_not_equal,
    input  logic                     id_halt,
    input  logic                     id_exception,
    output logic                     pc_load,
    output logic                     ir_load,
    output logic                     idex_bubble,
    output logic                     if_squash,
    output logic                     halt,
    output logic                     exception,
    output logic                     pipe_empty,
    output logic [CNT_BITS-1:0]      stall_count
);

    state_t state;
    logic   id_valid;
    logic   hazard;
    logic   run;
    logic   stall;
    logic   taken;
    logic   stop;
    logic   push;

    assign run   = (state == RUN);
    assign stall = run & hazard;
    assign stop  = id_valid & (id_halt | id_exception);
    assign taken = id_valid
                 & (id_jmp | id_jreg
                 | (id_breq & id_equal)
                 | (id_brne & id_not_equal));
    assign push  = run & id_valid & ~id_rw_ & ~stall & ~stop;

    hazard_scoreboard #(
        .REG_ADDR_BITS (REG_ADDR_BITS),
        .DEPTH         (DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_       (rst_),
        .push       (push),
        .push_addr  (id_waddr),
        .chk_valid  (id_valid),
        .use_r1     (id_use_r1),
        .use_r2     (id_use_r2),
        .r1_addr    (id_r1_addr),
        .r2_addr    (id_r2_addr),
        .hazard     (hazard),
        .pipe_empty (pipe_empty)
    );

    // A halt/exception in ID freezes fetch and leaves as a bubble
    always_comb begin
        pc_load     = run & ~stall & ~stop;
        ir_load     = run & ~stall & ~stop;
        idex_bubble = ~run | ~id_valid | stall | stop;
        if_squash   = ~run | (taken & ~stall & ~stop);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= RUN;
            id_valid    <= 1'b0;
            halt        <= 1'b0;
            exception   <= 1'b0;
            stall_count <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (stall) begin
                        if (stall_count != '1) begin
                            stall_count <= stall_count + CNT_BITS'(1);
                        end
                    end else if (stop) begin
                        state     <= DRAIN;
                        exception <= id_exception;
                        id_valid  <= 1'b0;
                    end else begin
                        id_valid <= ~if_squash;
                    end
                end
                DRAIN: begin
                    id_valid <= 1'b0;
                    if (pipe_empty) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end
                end
                HALTED: begin
                    id_valid <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Cycle-table bench for pipe_hazard_ctrl: each row is the instruction
// in ID for one cycle plus the outputs expected in that cycle.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       rw_;
        logic [4:0] wa;
        logic       jmp;
        logic       jreg;
        logic       breq;
        logic       brne;
        logic       eq;
        logic       ne;
        logic       hlt;
        logic       exc;
    } dec_t;

    // exp = {pc_load, ir_load, idex_bubble, if_squash, halt, exception, pipe_empty}
    typedef struct {
        dec_t        d;
        logic [6:0]  exp;
        logic [15:0] cnt;
        string       tag;
    } vec_t;

    logic        clk;
    logic        rst_;
    logic [4:0]  id_r1_addr;
    logic [4:0]  id_r2_addr;
    logic        id_use_r1;
    logic        id_use_r2;
    logic        id_rw_;
    logic [4:0]  id_waddr;
    logic        id_jmp;
    logic        id_jreg;
    logic        id_breq;
    logic        id_brne;
    logic        id_equal;
    logic        id_not_equal;
    logic        id_halt;
    logic        id_exception;
    logic        pc_load;
    logic        ir_load;
    logic        idex_bubble;
    logic        if_squash;
    logic        halt;
    logic        exception;
    logic        pipe_empty;
    logic [15:0] stall_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    vec_t expq[$];

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst_         (rst_),
        .id_r1_addr   (id_r1_addr),
        .id_r2_addr   (id_r2_addr),
        .id_use_r1    (id_use_r1),
        .id_use_r2    (id_use_r2),
        .id_rw_       (id_rw_),
        .id_waddr     (id_waddr),
        .id_jmp       (id_jmp),
        .id_jreg      (id_jreg),
        .id_breq      (id_breq),
        .id_brne      (id_brne),
        .id_equal     (id_equal),
        .id_not_equal (id_not_equal),
        .id_halt      (id_halt),
        .id_exception (id_exception),
        .pc_load      (pc_load),
        .ir_load      (ir_load),
        .idex_bubble  (idex_bubble),
        .if_squash    (if_squash),
        .halt         (halt),
        .exception    (exception),
        .pipe_empty   (pipe_empty),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    function automatic dec_t nop();
        dec_t d;
        d = '0;
        d.rw_ = 1'b1;
        return d;
    endfunction

    function automatic dec_t alu(int w, int a, int b);
        dec_t d;
        d = nop();
        d.rw_ = 1'b0;
        d.wa = 5'(w);
        d.r1 = 5'(a);
        d.r2 = 5'(b);
        d.u1 = 1'b1;
        d.u2 = 1'b1;
        return d;
    endfunction

    function automatic dec_t rd(int a);
        dec_t d;
        d = nop();
        d.r1 = 5'(a);
        d.u1 = 1'b1;
        return d;
    endfunction

    function automatic dec_t beq(int a, int b);
        dec_t d;
        d = nop();
        d.r1 = 5'(a);
        d.r2 = 5'(b);
        d.u1 = 1'b1;
        d.u2 = 1'b1;
        d.breq = 1'b1;
        d.eq = 1'b1;
        return d;
    endfunction

    function automatic dec_t hlt(logic ex);
        dec_t d;
        d = nop();
        d.hlt = 1'b1;
        d.exc = ex;
        return d;
    endfunction

    task automatic add(dec_t d, logic [6:0] e, int c, string tag);
        vec_t v;
        v.d = d;
        v.exp = e;
        v.cnt = 16'(c);
        v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic drive(dec_t d);
        id_r1_addr   = d.r1;
        id_r2_addr   = d.r2;
        id_use_r1    = d.u1;
        id_use_r2    = d.u2;
        id_rw_       = d.rw_;
        id_waddr     = d.wa;
        id_jmp       = d.jmp;
        id_jreg      = d.jreg;
        id_breq      = d.breq;
        id_brne      = d.brne;
        id_equal     = d.eq;
        id_not_equal = d.ne;
        id_halt      = d.hlt;
        id_exception = d.exc;
    endtask

    task automatic check(string tag, logic [6:0] e, logic [15:0] c);
        logic [6:0] got;
        got = {pc_load, ir_load, idex_bubble, if_squash,
               halt, exception, pipe_empty};
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s ctl: got %b want %b", tag, got, e);
        end
        n_cmp++;
        if (stall_count !== c) begin
            n_bad++;
            $display("FAIL %s cnt: got %0d want %0d",
                     tag, stall_count, c);
        end
    endtask

    // Drive each row, expect its outputs before the next edge
    task automatic run_vecs();
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d);
            expq.push_back(vecs[i]);
            @(negedge clk);
            v = expq.pop_front();
            check($sformatf("%s[%0d]", v.tag, i), v.exp, v.cnt);
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        drive(nop());
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
    endtask

    task automatic exc_prefix();
        add(nop(),          7'b1110001, 0, "x_reset");
        add(alu(12, 0, 0),  7'b1100001, 0, "x_w12");
        add(hlt(1'b1),      7'b0010000, 0, "x_exc");
        add(nop(),          7'b0011010, 0, "x_drain");
    endtask

    initial begin
        do_reset();

        add(nop(),          7'b1110001, 0, "reset");
        add(alu(3, 1, 2),   7'b1100001, 0, "w3");
        add(alu(4, 3, 0),   7'b0010000, 0, "raw_ex");
        add(alu(4, 3, 0),   7'b0010000, 1, "raw_mem");
        add(alu(4, 3, 0),   7'b0010000, 2, "raw_wb");
        add(alu(4, 3, 0),   7'b1100001, 3, "raw_go");
        add(alu(0, 1, 1),   7'b1100000, 3, "w0");
        add(rd(0),          7'b1100000, 3, "rd0");
        add(beq(5, 6),      7'b1101000, 3, "beq");
        add(alu(7, 0, 0),   7'b1110001, 3, "sq_slot");
        add(rd(7),          7'b1100001, 3, "rd7");
        add(alu(8, 1, 0),   7'b1100001, 3, "lw8");
        add(beq(8, 9),      7'b0010000, 3, "beq_st");
        add(beq(8, 9),      7'b0010000, 4, "beq_st");
        add(beq(8, 9),      7'b0010000, 5, "beq_st");
        add(beq(8, 9),      7'b1101001, 6, "beq_go");
        add(nop(),          7'b1110001, 6, "sq_slot2");
        add(alu(10, 0, 0),  7'b1100001, 6, "w10");
        add(alu(11, 0, 0),  7'b1100000, 6, "w11");
        add(hlt(1'b0),      7'b0010000, 6, "halt_id");
        add(rd(11),         7'b0011000, 6, "drain");
        add(rd(11),         7'b0011000, 6, "drain");
        add(nop(),          7'b0011001, 6, "drained");
        add(nop(),          7'b0011101, 6, "halted");
        add(nop(),          7'b0011101, 6, "halted");
        run_vecs();

        do_reset();
        exc_prefix();
        add(nop(),          7'b0011010, 0, "x_drain");
        add(nop(),          7'b0011011, 0, "x_empty");
        add(nop(),          7'b0011111, 0, "x_halted");
        add(nop(),          7'b0011111, 0, "x_halted");
        run_vecs();

        do_reset();
        exc_prefix();
        run_vecs();
        rst_ = 1'b0;
        #1;
        check("async_rst", 7'b1110001, 16'd0);
        #3;
        rst_ = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage cpu3 datapath (IF, ID, EX, MEM, WB).
- Tracks in-flight register writers in a shadow scoreboard.
- Detects RAW hazards in the decode stage, since there is no forwarding and the regfile has no write-to-read bypass.
- Generates PC/instruction-register load enables, ID/EX bubble insertion and IF squash on taken control transfers.
- Sequences orderly pipeline drain on halt or exception, and keeps a saturating stall counter.

Parameters:
REG_ADDR_BITS, 5, width of register addresses
DEPTH, 3, scoreboard stages tracked after ID (EX, MEM, WB)
CNT_BITS, 16, stall counter width

Ports:
clk  input  1  system clock
rst_  input  1  reset, asynchronous, active-low
id_r1_addr  input  REG_ADDR_BITS  decode source 1 address
id_r2_addr  input  REG_ADDR_BITS  decode source 2 address
id_use_r1  input  1  decode instruction reads source 1
id_use_r2  input  1  decode instruction reads source 2
id_rw_  input  1  decode instruction writes regfile (active-low)
id_waddr  input  REG_ADDR_BITS  decode destination address
id_jmp, id_jreg, id_breq, id_brne  input  1 each  decode control-transfer flags
id_equal, id_not_equal  input  1 each  equality results for the decode operands
id_halt  input  1  halt decoded
id_exception  input  1  illegal opcode decoded
pc_load  output  1  advance program counter
ir_load  output  1  load instruction register
idex_bubble  output  1  force ID/EX register to NOP (rw_=1, mem_rw_=1, halt=0)
if_squash  output  1  replace the next instruction-register load with NOP
halt  output  1  pipeline drained after halt; sticky
exception  output  1  exception taken; sticky
pipe_empty  output  1  no valid scoreboard entries
stall_count  output  CNT_BITS  cycles stalled on hazards; saturating

Behaviour:
- Reset:
  - scoreboard cleared; id_valid=0; state=RUN; stall_count=0.
  - Outputs: pc_load=1, ir_load=1, idex_bubble=1, if_squash=0, halt=0, exception=0, pipe_empty=1.
- id_valid register:
  - Set to 1 on a cycle where ir_load=1 and if_squash=0.
  - Cleared on squash or in DRAIN. All decode inputs are ignored when id_valid=0.
- Scoreboard: DEPTH entries of {valid, waddr}, shifting every cycle.
  - Entry 0 is loaded with {id_valid & ~id_rw_ & ~stall & run, id_waddr}.
  - Writes to register 0 are never recorded.
- Hazard, combinational: id_valid & (src1 or src2 match).
  - srcN match = id_use_rN & (id_rN_addr!=0) & any valid entry has waddr==id_rN_addr.
- Stall (hazard in RUN):
  - pc_load=0, ir_load=0, idex_bubble=1, no scoreboard push.
  - stall_count+1, saturating at all-ones.
- Taken transfer = id_jmp | id_jreg | (id_breq&id_equal) | (id_brne&id_not_equal), qualified by id_valid.
  - Not stalled: pc_load=1, if_squash=1 for exactly one cycle, so the wrong-path fetch becomes a NOP.
  - Stalled: the stall wins, and the transfer is evaluated again when the hazard clears.
- FSM RUN, DRAIN, HALTED:
  - RUN -> DRAIN on an unstalled id_valid & (id_halt | id_exception).
    - The halt or exception instruction itself is pushed as a bubble.
    - exception is set the same edge when id_exception=1; exception has priority if both are set.
  - DRAIN: pc_load=0, ir_load=0, idex_bubble=1, if_squash=1. Scoreboard keeps shifting in invalid entries.
  - DRAIN -> HALTED when pipe_empty=1. halt=1 from that edge onward.
  - HALTED: absorbing until reset. Outputs are frozen as in DRAIN.
  - A hazard present during DRAIN is not counted.
- Reset asserted mid-drain returns to RUN immediately; the sticky flags clear.
- pipe_empty = ~|valid, combinational from the registered scoreboard.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum {RUN, DRAIN, HALTED};
  - scoreboard entry struct {valid, waddr};
  - NOP control-bundle constant used by pipe_id_ex on idex_bubble.
- Sub-module hazard_scoreboard: shift register plus match logic. Outputs hazard and pipe_empty.
- FSM, counter and enables live in the top module.

Test Plan:
- add r3 writes, followed immediately by sub reading r3 -> 3 stall cycles (r3 in EX, MEM, WB); pc_load=0 for exactly 3 cycles; stall_count=3.
- add writing r0, then a reader of r0 -> no stall; stall_count stays 0.
- beq with id_equal=1 and no hazard -> if_squash=1 for one cycle, pc_load=1; next id_valid=0; no scoreboard push from the squashed slot.
- beq whose source hazards on the prior lw -> stall 3 cycles with if_squash=0, then one cycle with if_squash=1.
- halt behind writers in EX and MEM -> DRAIN; halt=1 after pipe_empty, about 3 cycles; pc_load=0 from the halt decode cycle onward.
- id_exception with id_halt in the same cycle -> exception=1 next edge, halt=1 after drain; rst_ pulse mid-drain -> all outputs at reset values asynchronously.
